// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
package mips_ctrl_pkg;

  typedef enum logic [4:0] {
    StRst    = 5'd0,
    StFetch  = 5'd1,
    StDecode = 5'd2,
    StRexec  = 5'd3,
    StRwb    = 5'd4,
    StIexec  = 5'd5,
    StIwb    = 5'd6,
    StMaddr  = 5'd7,
    StMread  = 5'd8,
    StLwb    = 5'd9,
    StMwrite = 5'd10,
    StBranch = 5'd11,
    StJump   = 5'd12,
    StExc    = 5'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_XOR = 6'h26;

  localparam logic [2:0] ALU_OP_ADD = 3'b001;
  localparam logic [2:0] ALU_OP_SUB = 3'b010;
  localparam logic [2:0] ALU_OP_AND = 3'b011;
  localparam logic [2:0] ALU_OP_XOR = 3'b110;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  typedef struct packed {
    logic       iord;
    logic       wr;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_sel;
    logic       pc_load;
    logic       ir_load;
    logic       mdr_load;
    logic       a_load;
    logic       b_load;
    logic       aluout_load;
    logic       epc_load;
    logic       pc_reset;
    logic       ir_reset;
    logic       mdr_reset;
    logic       a_reset;
    logic       b_reset;
    logic       aluout_reset;
    logic       reg_reset;
  } ctrl_t;

endpackage

// File: rtl/mips_alu_decode.sv
// R-type funct decode: ALU operation, legality and whether the op can overflow.
module mips_alu_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_sel,
  output logic       legal,
  output logic       arith
);

  always_comb begin
    alu_sel = ALU_OP_ADD;
    legal   = 1'b1;
    arith   = 1'b0;
    case (funct)
      FUNCT_ADD: begin
        alu_sel = ALU_OP_ADD;
        arith   = 1'b1;
      end
      FUNCT_SUB: begin
        alu_sel = ALU_OP_SUB;
        arith   = 1'b1;
      end
      FUNCT_AND: alu_sel = ALU_OP_AND;
      FUNCT_XOR: alu_sel = ALU_OP_XOR;
      default:   legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: fetch/decode/execute/mem/writeback plus trap handling.
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT    = 1,
  parameter logic [2:0]  EXC_ALU_SUB = 3'b010,
  parameter logic [2:0]  ALU_ADD     = 3'b001
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       ALU_zero,
  input  logic       ALU_overflow,
  output logic [4:0] StateOut,
  output logic       IorD,
  output logic       wr,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALU_sel,
  output logic       PC_load,
  output logic       IR_load,
  output logic       MDR_load,
  output logic       A_load,
  output logic       B_load,
  output logic       ALUOut_load,
  output logic       EPC_load,
  output logic       PC_reset,
  output logic       IR_reset,
  output logic       MDR_reset,
  output logic       A_reset,
  output logic       B_reset,
  output logic       ALUOut_reset,
  output logic       RegReset
);

  localparam logic [2:0] WaitLast = 3'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wait_done;
  logic [2:0] dec_sel;
  logic       funct_legal, funct_arith;
  ctrl_t      c, c_out;

  mips_alu_decode u_alu_decode (
    .funct   (Funct),
    .alu_sel (dec_sel),
    .legal   (funct_legal),
    .arith   (funct_arith)
  );

  assign wait_done = (cnt_q == WaitLast);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRst;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? 3'd0 : cnt_d;
    end
  end

  always_comb begin
    c       = '0;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRst: begin
        c.pc_reset     = 1'b1;
        c.ir_reset     = 1'b1;
        c.mdr_reset    = 1'b1;
        c.a_reset      = 1'b1;
        c.b_reset      = 1'b1;
        c.aluout_reset = 1'b1;
        c.reg_reset    = 1'b1;
        state_d        = StFetch;
      end
      StFetch: begin
        if (wait_done) begin
          c.ir_load   = 1'b1;
          c.pc_load   = 1'b1;
          c.pc_source = PCSRC_ALU;
          c.alu_src_b = SRCB_FOUR;
          c.alu_sel   = ALU_ADD;
          state_d     = StDecode;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDecode: begin
        // Speculatively compute the branch target into ALUOut.
        c.a_load      = 1'b1;
        c.b_load      = 1'b1;
        c.aluout_load = 1'b1;
        c.alu_src_b   = SRCB_BOFF;
        c.alu_sel     = ALU_ADD;
        case (Op)
          OP_RTYPE:      state_d = funct_legal ? StRexec : StExc;
          OP_LW, OP_SW:  state_d = StMaddr;
          OP_BEQ, OP_BNE: state_d = StBranch;
          OP_J:          state_d = StJump;
          OP_ADDI:       state_d = StIexec;
          default:       state_d = StExc;
        endcase
      end
      StRexec: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_B;
        c.alu_sel     = dec_sel;
        c.aluout_load = 1'b1;
        state_d       = StRwb;
      end
      StRwb: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_sel   = dec_sel;
        if (funct_arith && ALU_overflow) begin
          state_d = StExc;
        end else begin
          c.reg_write = 1'b1;
          c.reg_dst   = 1'b1;
          state_d     = StFetch;
        end
      end
      StIexec, StMaddr: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_IMM;
        c.alu_sel     = ALU_ADD;
        c.aluout_load = 1'b1;
        if (state_q == StIexec) state_d = StIwb;
        else                    state_d = (Op == OP_LW) ? StMread : StMwrite;
      end
      StIwb: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_sel   = ALU_ADD;
        if (ALU_overflow) begin
          state_d = StExc;
        end else begin
          c.reg_write = 1'b1;
          state_d     = StFetch;
        end
      end
      StMread: begin
        c.iord = 1'b1;
        if (wait_done) begin
          c.mdr_load = 1'b1;
          state_d    = StLwb;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StLwb: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        state_d      = StFetch;
      end
      StMwrite: begin
        c.iord  = 1'b1;
        c.wr    = 1'b1;
        state_d = StFetch;
      end
      StBranch: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_sel   = EXC_ALU_SUB;
        c.pc_source = PCSRC_ALUOUT;
        c.pc_load   = (Op == OP_BNE) ? !ALU_zero : ALU_zero;
        state_d     = StFetch;
      end
      StJump: begin
        c.pc_source = PCSRC_JUMP;
        c.pc_load   = 1'b1;
        state_d     = StFetch;
      end
      StExc: begin
        // EPC <= PC - 4 since PC was already advanced in FETCH.
        c.alu_src_b = SRCB_FOUR;
        c.alu_sel   = EXC_ALU_SUB;
        c.epc_load  = 1'b1;
        c.pc_source = PCSRC_EXC;
        c.pc_load   = 1'b1;
        state_d     = StFetch;
      end
      default: state_d = StRst;
    endcase
  end

  // Reset low forces every control line inactive immediately.
  assign c_out = reset ? c : '0;

  assign StateOut     = state_q;
  assign IorD         = c_out.iord;
  assign wr           = c_out.wr;
  assign MemtoReg     = c_out.mem_to_reg;
  assign RegDst       = c_out.reg_dst;
  assign RegWrite     = c_out.reg_write;
  assign ALUSrcA      = c_out.alu_src_a;
  assign ALUSrcB      = c_out.alu_src_b;
  assign PCSource     = c_out.pc_source;
  assign ALU_sel      = c_out.alu_sel;
  assign PC_load      = c_out.pc_load;
  assign IR_load      = c_out.ir_load;
  assign MDR_load     = c_out.mdr_load;
  assign A_load       = c_out.a_load;
  assign B_load       = c_out.b_load;
  assign ALUOut_load  = c_out.aluout_load;
  assign EPC_load     = c_out.epc_load;
  assign PC_reset     = c_out.pc_reset;
  assign IR_reset     = c_out.ir_reset;
  assign MDR_reset    = c_out.mdr_reset;
  assign A_reset      = c_out.a_reset;
  assign B_reset      = c_out.b_reset;
  assign ALUOut_reset = c_out.aluout_reset;
  assign RegReset     = c_out.reg_reset;

endmodule
